// File: rtl/temporal_decoder.sv
// -----------------------------------------------------------------------------
// temporal_decoder
//
// Inverse of the temporal (N-gram) encoder. Each incoming N-gram hypervector
//   y_t = x_t ^ rho(x_{t-1}) ^ ... ^ rho^(N-1)(x_{t-N+1})
// is turned back into the sample hypervector x_t by XOR-ing away the
// contribution of the previously decoded vectors. Those contributions are
// kept here as a permuted history, so the decoder needs no side channel from
// the encoder.
//
// Ports
//   Clk_CI            clock, rising edge
//   Reset_RBI         asynchronous reset, active low
//   Clear_SI          synchronous sequence-boundary clear of history and count
//   ValidIn_SI        upstream N-gram vector valid
//   ReadyOut_SO       decoder can accept an input this cycle
//   HypervectorIn_DI  N-gram hypervector y_t, bit order [0:D-1]
//   ValidOut_SO       decoded vector valid
//   ReadyIn_SI        downstream accepts the output
//   HypervectorOut_DO decoded x_t (registered), bit order [0:D-1]
//   HistoryFull_SO    at least N-1 vectors decoded since reset or clear
// -----------------------------------------------------------------------------

`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif

`ifndef NGRAM_SIZE
`define NGRAM_SIZE 3
`endif

module temporal_decoder #(
  parameter int unsigned HV_DIMENSION = `HV_DIMENSION,
  parameter int unsigned NGRAM_SIZE   = `NGRAM_SIZE
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RBI,
  input  logic                     Clear_SI,
  input  logic                     ValidIn_SI,
  output logic                     ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1]  HypervectorIn_DI,
  output logic                     ValidOut_SO,
  input  logic                     ReadyIn_SI,
  output logic [0:HV_DIMENSION-1]  HypervectorOut_DO,
  output logic                     HistoryFull_SO
);

  // History depth is N-1; the count only has to reach N-1.
  localparam int unsigned HIST_DEPTH = NGRAM_SIZE - 1;
  localparam int unsigned CNT_W      = $clog2(NGRAM_SIZE);

  localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(HIST_DEPTH);
  localparam logic [0:HV_DIMENSION-1] ZERO_HV  = {HV_DIMENSION{1'b0}};

  // FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FWD  = 1'b1;

  // Permutation shared with the encoder: rotate by one toward higher index,
  // the last bit wraps around into bit 0.
  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] v);
    rho = {v[HV_DIMENSION-1], v[0:HV_DIMENSION-2]};
  endfunction

  logic [0:0]              state_r;
  logic [0:0]              state_next_s;
  logic [0:HV_DIMENSION-1] hist_r [1:HIST_DEPTH];
  logic [0:HV_DIMENSION-1] hist_xor_s;
  logic [0:HV_DIMENSION-1] x_s;
  logic [0:HV_DIMENSION-1] out_r;
  logic [CNT_W-1:0]        count_r;
  logic                    ready_s;
  logic                    accept_s;

  // Ready: always free when idle, otherwise only when the held output drains.
  always_comb begin
    ready_s = 1'b1;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      FWD:     ready_s = ReadyIn_SI;
      default: ready_s = 1'b1;
    endcase
  end

  assign accept_s = ValidIn_SI & ready_s;

  // Decode against the pre-update history; a same-cycle clear means the
  // history is treated as all zeros, so the input passes straight through.
  always_comb begin
    hist_xor_s = ZERO_HV;
    for (int k = 1; k <= int'(HIST_DEPTH); k++) begin
      hist_xor_s = hist_xor_s ^ hist_r[k];
    end
    if (Clear_SI) begin
      x_s = HypervectorIn_DI;
    end else begin
      x_s = HypervectorIn_DI ^ hist_xor_s;
    end
  end

  // Next-state logic of the two-state output handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = FWD;
        end else begin
          state_next_s = IDLE;
        end
      end
      FWD: begin
        // Output consumed with nothing new behind it -> go idle.
        if (ReadyIn_SI && !ValidIn_SI) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FWD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register; clear deliberately leaves a pending output alone.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Permuted history: each accept shifts every entry one slot deeper and
  // permutes it once more, so Hist[k] always holds rho^k(x_{t-k}).
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      for (int k = 1; k <= int'(HIST_DEPTH); k++) begin
        hist_r[k] <= ZERO_HV;
      end
    end else if (accept_s) begin
      hist_r[1] <= rho(x_s);
      for (int k = 2; k <= int'(HIST_DEPTH); k++) begin
        if (Clear_SI) begin
          hist_r[k] <= ZERO_HV;
        end else begin
          hist_r[k] <= rho(hist_r[k-1]);
        end
      end
    end else if (Clear_SI) begin
      for (int k = 1; k <= int'(HIST_DEPTH); k++) begin
        hist_r[k] <= ZERO_HV;
      end
    end else begin
      for (int k = 1; k <= int'(HIST_DEPTH); k++) begin
        hist_r[k] <= hist_r[k];
      end
    end
  end

  // Saturating count of decoded vectors since reset or clear.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      count_r <= CNT_ZERO;
    end else if (accept_s) begin
      if (Clear_SI) begin
        count_r <= CNT_ONE;
      end else if (count_r == CNT_MAX) begin
        count_r <= CNT_MAX;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
    end else if (Clear_SI) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r;
    end
  end

  // Output register, loaded only on accept so it is stable under backpressure.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      out_r <= ZERO_HV;
    end else if (accept_s) begin
      out_r <= x_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign ReadyOut_SO       = ready_s;
  assign ValidOut_SO       = (state_r == FWD);
  assign HypervectorOut_DO = out_r;
  assign HistoryFull_SO    = (count_r == CNT_MAX);

endmodule

// File: tb/tb_temporal_decoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_decoder
//
// Directed bench for temporal_decoder with D=8, N=3, followed by an
// encoder->decoder loopback using a behavioural N-gram encoder and random
// downstream stalls. Hex values are written with bit[0] as the MSB.
// -----------------------------------------------------------------------------
module tb_temporal_decoder;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       valid_in;
  logic       ready_out;
  logic [0:7] din;
  logic       valid_out;
  logic       ready_in;
  logic [0:7] dout;
  logic       hist_full;

  int checks;
  int errors;

  temporal_decoder #(
    .HV_DIMENSION(8),
    .NGRAM_SIZE  (3)
  ) dut (
    .Clk_CI           (clk),
    .Reset_RBI        (rst_n),
    .Clear_SI         (clear),
    .ValidIn_SI       (valid_in),
    .ReadyOut_SO      (ready_out),
    .HypervectorIn_DI (din),
    .ValidOut_SO      (valid_out),
    .ReadyIn_SI       (ready_in),
    .HypervectorOut_DO(dout),
    .HistoryFull_SO   (hist_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted-input cycle; outputs are observed 1 time unit after the edge.
  task automatic push(input logic [7:0] y, input logic clr);
    @(negedge clk);
    valid_in = 1'b1;
    din      = y;
    ready_in = 1'b1;
    clear    = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [0:7] rho(input logic [0:7] v);
    rho = {v[7], v[0:6]};
  endfunction

  // Loopback state
  logic [0:7] q[$];
  logic [0:7] x_cur;
  logic [0:7] y_cur;
  logic [0:7] enc_h1;
  logic [0:7] enc_h2;
  logic [0:7] exp_v;
  logic       acc;
  logic       xfer;
  int         sent;
  int         got;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    valid_in = 1'b0;
    din      = 8'h00;
    ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 32'(valid_out), 32'h0);
    check("rst_ready_out", 32'(ready_out), 32'h1);
    check("rst_dout",      32'(dout),      32'h00);
    check("rst_hist_full", 32'(hist_full), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single steps
    push(8'h80, 1'b0);
    check("s1_dout", 32'(dout), 32'h80);
    check("s1_valid", 32'(valid_out), 32'h1);
    check("s1_full", 32'(hist_full), 32'h0);
    push(8'h40, 1'b0);
    check("s2_dout", 32'(dout), 32'h00);
    check("s2_full", 32'(hist_full), 32'h1);
    push(8'h00, 1'b0);
    check("s3_dout", 32'(dout), 32'h20);
    check("s3_full", 32'(hist_full), 32'h1);

    // Async reset while an output is pending
    check("ar_pre_valid", 32'(valid_out), 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(valid_out), 32'h0);
    check("ar_dout",  32'(dout),      32'h00);
    check("ar_full",  32'(hist_full), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h80, 1'b0);
    check("ar_next_dout", 32'(dout), 32'h80);

    // Wrap-around of the permutation
    do_reset();
    push(8'h01, 1'b0);
    check("wr1_dout", 32'(dout), 32'h01);
    push(8'h80, 1'b0);
    check("wr2_dout", 32'(dout), 32'h00);

    // Backpressure
    do_reset();
    push(8'h80, 1'b0);
    check("bp0_dout", 32'(dout), 32'h80);
    @(negedge clk);
    valid_in = 1'b1;
    din      = 8'h40;
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_dout",  32'(dout),      32'h80);
      check("bp_hold_valid", 32'(valid_out), 32'h1);
      check("bp_hold_ready", 32'(ready_out), 32'h0);
    end
    check("bp_hold_full", 32'(hist_full), 32'h0);
    @(negedge clk);
    ready_in = 1'b1;
    #1;
    check("bp_ready_pass", 32'(ready_out), 32'h1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("bp_rel_dout",  32'(dout),      32'h00);
    check("bp_rel_valid", 32'(valid_out), 32'h1);
    check("bp_rel_full",  32'(hist_full), 32'h1);

    // Clear with and without a simultaneous accept
    do_reset();
    push(8'h80, 1'b0);
    push(8'h40, 1'b0);
    check("cl_pre_full", 32'(hist_full), 32'h1);
    push(8'h55, 1'b1);
    check("cl_dout", 32'(dout), 32'h55);
    check("cl_full", 32'(hist_full), 32'h0);
    push(8'h00, 1'b0);
    check("cl_next_dout", 32'(dout), 32'hAA);
    check("cl_next_full", 32'(hist_full), 32'h1);
    @(negedge clk);
    ready_in = 1'b0;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clh_dout",  32'(dout),      32'hAA);
    check("clh_valid", 32'(valid_out), 32'h1);
    check("clh_full",  32'(hist_full), 32'h0);

    // Encoder -> decoder loopback with random stalls
    do_reset();
    enc_h1 = 8'h00;
    enc_h2 = 8'h00;
    sent   = 0;
    got    = 0;
    x_cur  = 8'($urandom);
    y_cur  = x_cur ^ rho(enc_h1) ^ rho(rho(enc_h2));
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      valid_in = (sent < 1000);
      din      = y_cur;
      ready_in = ($urandom_range(0, 3) != 0);
      #1;
      acc  = valid_in & ready_out;
      xfer = valid_out & ready_in;
      if (xfer) begin
        if (q.size() == 0) begin
          exp_v = 8'hxx;
        end else begin
          exp_v = q.pop_front();
        end
        check("rt_data", 32'(dout), 32'(exp_v));
        got++;
      end
      if (acc) begin
        q.push_back(x_cur);
        enc_h2 = enc_h1;
        enc_h1 = x_cur;
        sent++;
        x_cur = 8'($urandom);
        y_cur = x_cur ^ rho(enc_h1) ^ rho(rho(enc_h2));
      end
      @(posedge clk);
    end
    #1;
    valid_in = 1'b0;
    check("rt_sent", 32'(sent), 32'd1000);
    check("rt_got",  32'(got),  32'd1000);
    check("rt_left", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporal_decoder.md
# temporal_decoder

Inverse of the temporal (N-gram) encoder. It takes a stream of N-gram hypervectors y_t = x_t ^ ρ(x_{t-1}) ^ … ^ ρ^(N-1)(x_{t-N+1}) and recovers the original sample hypervectors x_t. It keeps its own permuted history of decoded vectors, so it sits after the encoder in loopback and reconstruction paths. It uses the same valid/ready handshake as the encoder.

## Interface
- HV_DIMENSION, default `HV_DIMENSION (const.vh), hypervector width D; bit order [0:D-1].
- NGRAM_SIZE, default `NGRAM_SIZE (const.vh), N ≥ 2; history depth N-1.
- Clk_CI  input  1  clock; all state updates on the rising edge.
- Reset_RBI  input  1  asynchronous reset, active-low.
- Clear_SI  input  1  synchronous sequence-boundary clear of history and count.
- ValidIn_SI  input  1  upstream N-gram vector valid.
- ReadyOut_SO  output  1  decoder can accept an input this cycle.
- HypervectorIn_DI  input  D  N-gram hypervector y_t.
- ValidOut_SO  output  1  decoded vector valid.
- ReadyIn_SI  input  1  downstream accepts the output.
- HypervectorOut_DO  output  D  decoded x_t (registered).
- HistoryFull_SO  output  1  at least N-1 vectors decoded since reset or clear.

## Operation
- ρ(v) = {v[D-1], v[0:D-2]}: rotate by one toward higher index. Identical to the encoder's permutation.
- History registers Hist[1..N-1], each D bits. Hist[k] holds ρ^k(x_{t-k}).
- Decode: x_t = HypervectorIn_DI ^ Hist[1] ^ … ^ Hist[N-1], using pre-update history values.
- On accept (ValidIn_SI & ReadyOut_SO):
  - Hist[1] ← ρ(x_t); Hist[k] ← ρ(Hist[k-1]) for k ≥ 2.
  - Output register ← x_t.
  - Count ← min(count+1, N-1).
- No accept: history, count and output register hold.
- FSM, 2 states:
  - IDLE: ValidOut_SO=0, ReadyOut_SO=1. Accept → FWD.
  - FWD: ValidOut_SO=1, ReadyOut_SO=ReadyIn_SI (combinational pass-through).
    - ReadyIn_SI=0: stay in FWD; output, history and count held.
    - ReadyIn_SI=1 and ValidIn_SI=1: output is consumed and a new input is accepted in the same cycle; stay in FWD with the new result.
    - ReadyIn_SI=1 and ValidIn_SI=0: → IDLE.
- HistoryFull_SO = (count == N-1). Count is ⌈log2 N⌉ bits and saturates at N-1.
- Clear_SI=1 at a clock edge:
  - All Hist ← 0 and count ← 0, applied before any same-cycle accept.
  - A simultaneous accept decodes against zero history: x_t = y_t. It then writes Hist[1]=ρ(x_t), all other Hist=0, count=1.
  - Clear does not alter the FSM state or a pending output.
- Round-trip requirement: an encoder and a decoder, both reset or cleared together, with the same D and N, fed the same sequence, give decoded output equal to the encoder input, bit for bit.

## Timing
- Reset (Reset_RBI=0, asynchronous):
  - FSM=IDLE, Hist=0, count=0, output register=0.
  - ValidOut_SO=0, ReadyOut_SO=1, HypervectorOut_DO=0, HistoryFull_SO=0.
  - Reset mid-transfer drops the pending output with no completion.
- Latency: a vector accepted at edge e appears on HypervectorOut_DO with ValidOut_SO=1 immediately after e (1 cycle).
- Throughput: one vector per cycle while ReadyIn_SI=1.
- Output stability: HypervectorOut_DO and ValidOut_SO stay stable while ValidOut_SO=1 and ReadyIn_SI=0.
- Handshake: an input is consumed only on a cycle with ValidIn_SI & ReadyOut_SO. Upstream holds data until then.
- Release: HistoryFull_SO rises on the edge that accepts the (N-1)-th vector.

## Test plan
All scenarios use D=8 and N=3 unless stated otherwise. Values are hex, with bit[0] as the MSB.
- Reset then single steps, ReadyIn=1:
  - y=80 → out 80.
  - y=40 → out 00.
  - y=00 → out 20.
  - HistoryFull rises after the second accept.
- Wrap-around: after reset, y=01 → out 01. Next y=80 → out 00 (Hist[1] was 80).
- Backpressure:
  - Accept y=80, then hold ReadyIn=0 for 5 cycles with ValidIn=1 and y=40.
  - Required: out stays 80 with ValidOut=1, ReadyOut=0, and no second accept.
  - Raise ReadyIn: 40 is accepted that cycle, and out=00 on the next cycle.
- Clear:
  - Decode 80, 40, then assert Clear with an accept of y=55 → out 55, count=1, HistoryFull=0.
  - Next y=00 → out AA (ρ(55)).
- Round trip: D=`HV_DIMENSION, N=`NGRAM_SIZE.
  - Encoder→decoder loopback with 1000 random vectors and random ReadyIn stalls.
  - Required: decoded stream equals encoder input, with zero mismatches and no drops or duplicates.
- Async reset asserted mid-stream while ValidOut=1 → same cycle: ValidOut=0, out=00, HistoryFull=0. Next y=80 → out 80.
